fractal_frame_sequencer: RTL and testbench
==========================================

// Module: fractal_frame_sequencer
// PURPOSE
//   Sequences and configures fractal_generator frame by frame. Owns the generator's resetn,
//   width/height and the c / viewport parameters. Animates c (cr, ci) ping-pong over
//   cfg_num_frames frames. Changes parameters only at frame boundaries, detected from the
//   generator's output stream. Re-resets the generator when the frame size changes.
// PARAMETERS
//   RESET_CYCLES  4   cycles gen_resetn is held low per generator (re)reset, >=1
// PORTS
//   clk              in   1   system clock
//   resetn           in   1   synchronous active-low reset
//   enable           in   1   1 = run animation; 0 = stop at next frame boundary
//   cfg_width        in   16  requested frame width, >=1
//   cfg_height       in   16  requested frame height, >=1
//   cfg_cr0/cfg_ci0  in   32  start value of c (Q4.28)
//   cfg_cr_step      in   32  per-frame increment of cr (Q4.28)
//   cfg_ci_step      in   32  per-frame increment of ci (Q4.28)
//   cfg_num_frames   in   16  frames per half ping-pong period; 0 or 1 = static c
//   cfg_dx/dy/x0/y0  in   32  viewport; sampled at frame boundaries
//   gen_frame_start  in   1   generator tuser
//   gen_line_end     in   1   generator tlast
//   gen_data_enable  in   1   generator tvalid
//   gen_resetn       out  1   generator reset, active low
//   width/height     out  16  to generator
//   cr/ci/dx/dy/x0/y0 out 32  to generator, registered
//   frame_done       out  1   1-cycle pulse per completed frame
//   frame_count      out  16  completed frames, wraps at 2^16
//   anim_dir         out  1   0 = c ascending, 1 = c descending
// BEHAVIOUR
//   Reset: state=IDLE. gen_resetn=0. All parameter outputs=0. frame_count=0, anim_dir=0,
//     frame_done=0, idx=0, line_cnt=0.
//   FSM states: IDLE, GEN_RST, RUN, UPDATE.
//   IDLE: gen_resetn=0. On enable=1, go to GEN_RST, loading:
//     width/height <= cfg; cr/ci <= cfg_cr0/ci0; dx..y0 <= cfg; idx=0; anim_dir=0.
//   GEN_RST: gen_resetn=0 for exactly RESET_CYCLES cycles, then RUN. In RUN, gen_resetn=1
//     and line_cnt=0.
//   RUN, beat = gen_data_enable:
//     beat && gen_frame_start sets line_cnt to 0 (resync) before the line_end check.
//     beat && gen_line_end && line_cnt==height-1 is the frame end: go to UPDATE,
//       line_cnt<=0.
//     beat && gen_line_end otherwise: line_cnt++.
//   UPDATE (exactly 1 cycle): frame_done=1; frame_count++; dx..y0 <= cfg. Then c steps:
//     cfg_num_frames<=1: no change.
//     anim_dir=0: cr+=cr_step, ci+=ci_step, idx++; if new idx==N-1 then anim_dir<=1.
//     anim_dir=1: cr-=cr_step, ci-=ci_step, idx--; if new idx==0 then anim_dir<=0.
//   Next state from UPDATE, in priority order:
//     enable=0 -> IDLE (c and frame_count are held).
//     cfg_width/height != width/height -> GEN_RST. Only width/height reload;
//       c, idx and frame_count are kept.
//     otherwise -> RUN.
//   Timing: all parameter outputs change only on the UPDATE edge or the IDLE->GEN_RST edge.
//     They are stable for the whole of RUN.
//   Arithmetic: 32-bit two's complement, wrapping, no saturation.
//   Enable or cfg changes mid-frame take effect only at the next UPDATE.
//   Generator stream inputs are ignored outside RUN.
//   Reset mid-operation returns to the reset values on the next edge.
// TESTING
//   1. 4x2 frame, RESET_CYCLES=4: enable -> gen_resetn low 4 cycles then high; after 8
//      beats (tlast on beats 4,8) -> frame_done pulses once, frame_count=1.
//   2. cr0=0, cr_step=0x0100_0000, N=3, frames 1..5 -> cr = 0x01..,0x02..,0x01..,0,0x01..;
//      anim_dir = 0,1,1,0,0.
//   3. Change cfg_cx0/dx mid-frame -> dx unchanged until the UPDATE cycle; value appears
//      the cycle after frame_done.
//   4. Change cfg_width 4->8 mid-frame -> frame completes at the old size, then GEN_RST
//      with gen_resetn low 4 cycles; width=8; cr kept.
//   5. Deassert enable mid-frame -> frame finishes, frame_done pulses, then IDLE with
//      gen_resetn=0. Re-enable -> cr reloads cfg_cr0.
//   6. width=1 (frame_start and line_end on the same beat), height=3 -> frame_done after
//      3 beats. N=0 -> cr constant.

Source files
------------

// File: rtl/fractal_frame_sequencer.sv
// ---------------------------------------------------------------------------
// fractal_frame_sequencer
//
// Drives a fractal_generator frame by frame. It owns the generator's reset,
// its frame size and its per-frame parameters (c and the viewport). It also
// animates c back and forth across cfg_num_frames frames. A new frame
// boundary is found by watching the generator's AXI-stream style output
// (tvalid / tuser / tlast). Parameters only change between frames. When the
// requested frame size changes, the generator is reset again.
//
// Ports
//   clk              in   1   system clock
//   resetn           in   1   synchronous active-low reset
//   enable           in   1   1 = run the animation, 0 = stop at the next frame boundary
//   cfg_width        in   16  requested frame width (>= 1)
//   cfg_height       in   16  requested frame height (>= 1)
//   cfg_cr0/cfg_ci0  in   32  start value of c (Q4.28)
//   cfg_cr_step      in   32  per-frame increment of cr (Q4.28)
//   cfg_ci_step      in   32  per-frame increment of ci (Q4.28)
//   cfg_num_frames   in   16  frames per half ping-pong period (0 or 1 = static c)
//   cfg_dx/dy/x0/y0  in   32  viewport, taken at frame boundaries
//   gen_frame_start  in   1   generator tuser
//   gen_line_end     in   1   generator tlast
//   gen_data_enable  in   1   generator tvalid
//   gen_resetn       out  1   generator reset, active low
//   width/height     out  16  frame size to the generator
//   cr/ci/dx/dy/x0/y0 out 32  per-frame parameters to the generator
//   frame_done       out  1   one-cycle pulse per completed frame
//   frame_count      out  16  completed frames (wraps)
//   anim_dir         out  1   0 = c ascending, 1 = c descending
// ---------------------------------------------------------------------------
module fractal_frame_sequencer #(
  parameter int RESET_CYCLES = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic [15:0] cfg_width,
  input  logic [15:0] cfg_height,
  input  logic [31:0] cfg_cr0,
  input  logic [31:0] cfg_ci0,
  input  logic [31:0] cfg_cr_step,
  input  logic [31:0] cfg_ci_step,
  input  logic [15:0] cfg_num_frames,
  input  logic [31:0] cfg_dx,
  input  logic [31:0] cfg_dy,
  input  logic [31:0] cfg_x0,
  input  logic [31:0] cfg_y0,
  input  logic        gen_frame_start,
  input  logic        gen_line_end,
  input  logic        gen_data_enable,
  output logic        gen_resetn,
  output logic [15:0] width,
  output logic [15:0] height,
  output logic [31:0] cr,
  output logic [31:0] ci,
  output logic [31:0] dx,
  output logic [31:0] dy,
  output logic [31:0] x0,
  output logic [31:0] y0,
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic        anim_dir
);

  localparam int RCW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RCW-1:0] RST_LAST = RCW'(RESET_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GEN_RST = 2'd1,
    RUN     = 2'd2,
    UPDATE  = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [RCW-1:0] rst_cnt;
  logic [15:0]    line_cnt;
  logic [15:0]    line_base;
  logic [15:0]    idx;
  logic [15:0]    idx_inc;
  logic [15:0]    idx_dec;
  logic [15:0]    n_last;
  logic           beat;
  logic           frame_end;
  logic           size_change;
  logic           start_run;
  logic           animate;

  // Decode the generator stream. A tuser beat resyncs the line counter to
  // zero before tlast is looked at, so a one-pixel-wide line is handled
  // in the same cycle that it starts.
  always_comb begin
    beat        = gen_data_enable;
    line_base   = gen_frame_start ? 16'd0 : line_cnt;
    frame_end   = (state == RUN) && beat && gen_line_end &&
                  (line_base == (height - 16'd1));
    size_change = (cfg_width != width) || (cfg_height != height);
    start_run   = (state == IDLE) && enable;
    animate     = (cfg_num_frames > 16'd1);
    idx_inc     = idx + 16'd1;
    idx_dec     = idx - 16'd1;
    n_last      = cfg_num_frames - 16'd1;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. UPDATE always lasts one cycle. It then picks, in
  // priority order: stop, re-reset the generator for a new size, or carry on.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (enable) begin
          state_next = GEN_RST;
        end
      end
      GEN_RST: begin
        if (rst_cnt == RST_LAST) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (frame_end) begin
          state_next = UPDATE;
        end
      end
      UPDATE: begin
        if (!enable) begin
          state_next = IDLE;
        end else if (size_change) begin
          state_next = GEN_RST;
        end else begin
          state_next = RUN;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Moore outputs. The generator stays out of reset through UPDATE, so a
  // frame that keeps its size runs straight on without a fresh reset.
  always_comb begin
    gen_resetn = 1'b0;
    frame_done = 1'b0;
    case (state)
      RUN:     gen_resetn = 1'b1;
      UPDATE: begin
        gen_resetn = 1'b1;
        frame_done = 1'b1;
      end
      default: begin
        gen_resetn = 1'b0;
        frame_done = 1'b0;
      end
    endcase
  end

  // Reset-hold counter. It counts the cycles spent in GEN_RST and is cleared
  // everywhere else, so every entry into GEN_RST gets the full hold time.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rst_cnt <= '0;
    end else if (state == GEN_RST) begin
      rst_cnt <= rst_cnt + RCW'(1);
    end else begin
      rst_cnt <= '0;
    end
  end

  // Line counter. It only advances on valid beats while in RUN. Outside RUN
  // it is held at zero, so each run starts counting from the first line.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      line_cnt <= 16'd0;
    end else if (state != RUN) begin
      line_cnt <= 16'd0;
    end else if (beat) begin
      if (gen_line_end) begin
        line_cnt <= frame_end ? 16'd0 : (line_base + 16'd1);
      end else begin
        line_cnt <= line_base;
      end
    end
  end

  // Frame size. It is loaded when leaving IDLE. It is reloaded on UPDATE only
  // when a new size forces the generator back through reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      width  <= 16'd0;
      height <= 16'd0;
    end else if (start_run ||
                 ((state == UPDATE) && enable && size_change)) begin
      width  <= cfg_width;
      height <= cfg_height;
    end
  end

  // Viewport. It is taken from the config on the start edge and on every
  // UPDATE edge, so it never moves while a frame is being generated.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      dx <= 32'd0;
      dy <= 32'd0;
      x0 <= 32'd0;
      y0 <= 32'd0;
    end else if (start_run || (state == UPDATE)) begin
      dx <= cfg_dx;
      dy <= cfg_dy;
      x0 <= cfg_x0;
      y0 <= cfg_y0;
    end
  end

  // c animation. idx tracks the position within the ping-pong. The direction
  // flips when the new idx reaches either end, so the end points are each
  // visited once per sweep. Wrapping two's-complement arithmetic throughout.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cr       <= 32'd0;
      ci       <= 32'd0;
      idx      <= 16'd0;
      anim_dir <= 1'b0;
    end else if (start_run) begin
      cr       <= cfg_cr0;
      ci       <= cfg_ci0;
      idx      <= 16'd0;
      anim_dir <= 1'b0;
    end else if ((state == UPDATE) && animate) begin
      if (!anim_dir) begin
        cr  <= cr + cfg_cr_step;
        ci  <= ci + cfg_ci_step;
        idx <= idx_inc;
        if (idx_inc == n_last) begin
          anim_dir <= 1'b1;
        end
      end else begin
        cr  <= cr - cfg_cr_step;
        ci  <= ci - cfg_ci_step;
        idx <= idx_dec;
        if (idx_dec == 16'd0) begin
          anim_dir <= 1'b0;
        end
      end
    end
  end

  // Completed-frame counter. It survives stop/restart and only clears on reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      frame_count <= 16'd0;
    end else if (state == UPDATE) begin
      frame_count <= frame_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_fractal_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fractal_frame_sequencer
//
// Directed bench for fractal_frame_sequencer. The stimulus process plays
// generator frames and queues the hand-computed state expected after each
// frame. A monitor pops one entry per frame_done pulse and compares it.
// ---------------------------------------------------------------------------
module tb_fractal_frame_sequencer;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable;
  logic [15:0] cfg_width;
  logic [15:0] cfg_height;
  logic [31:0] cfg_cr0;
  logic [31:0] cfg_ci0;
  logic [31:0] cfg_cr_step;
  logic [31:0] cfg_ci_step;
  logic [15:0] cfg_num_frames;
  logic [31:0] cfg_dx;
  logic [31:0] cfg_dy;
  logic [31:0] cfg_x0;
  logic [31:0] cfg_y0;
  logic        gen_frame_start;
  logic        gen_line_end;
  logic        gen_data_enable;
  logic        gen_resetn;
  logic [15:0] width;
  logic [15:0] height;
  logic [31:0] cr;
  logic [31:0] ci;
  logic [31:0] dx;
  logic [31:0] dy;
  logic [31:0] x0;
  logic [31:0] y0;
  logic        frame_done;
  logic [15:0] frame_count;
  logic        anim_dir;

  int n_compared   = 0;
  int n_mismatched = 0;

  typedef struct {
    logic [15:0] fc;
    logic [31:0] cr;
    logic [31:0] ci;
    logic        dir;
    logic [31:0] dx_pre;
    logic [31:0] dx_post;
    logic [15:0] width;
  } exp_t;

  exp_t sb[$];

  fractal_frame_sequencer #(.RESET_CYCLES(4)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .enable          (enable),
    .cfg_width       (cfg_width),
    .cfg_height      (cfg_height),
    .cfg_cr0         (cfg_cr0),
    .cfg_ci0         (cfg_ci0),
    .cfg_cr_step     (cfg_cr_step),
    .cfg_ci_step     (cfg_ci_step),
    .cfg_num_frames  (cfg_num_frames),
    .cfg_dx          (cfg_dx),
    .cfg_dy          (cfg_dy),
    .cfg_x0          (cfg_x0),
    .cfg_y0          (cfg_y0),
    .gen_frame_start (gen_frame_start),
    .gen_line_end    (gen_line_end),
    .gen_data_enable (gen_data_enable),
    .gen_resetn      (gen_resetn),
    .width           (width),
    .height          (height),
    .cr              (cr),
    .ci              (ci),
    .dx              (dx),
    .dy              (dy),
    .x0              (x0),
    .y0              (y0),
    .frame_done      (frame_done),
    .frame_count     (frame_count),
    .anim_dir        (anim_dir)
  );

  // 100 MHz style clock.
  always #5 clk = ~clk;

  // One comparison. Every pass and fail goes through here.
  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Queue the state expected once a frame completes.
  task automatic expect_frame(input logic [15:0] fc, input logic [31:0] cr_e,
                              input logic [31:0] ci_e, input logic dir_e,
                              input logic [31:0] dx_pre, input logic [31:0] dx_post,
                              input logic [15:0] w_e);
    exp_t e;
    e.fc      = fc;
    e.cr      = cr_e;
    e.ci      = ci_e;
    e.dir     = dir_e;
    e.dx_pre  = dx_pre;
    e.dx_post = dx_post;
    e.width   = w_e;
    sb.push_back(e);
  endtask

  // Plays one w x h frame, one beat per cycle. Between lines there is an idle
  // cycle that carries junk tuser/tlast with tvalid low. mid_kind changes one
  // control after the first beat: 1 = dx, 2 = width to 8, 3 = drop enable.
  // The task is entered and left on a falling edge.
  task automatic apply_stimulus(input int w, input int h, input int mid_kind);
    for (int l = 0; l < h; l++) begin
      for (int p = 0; p < w; p++) begin
        gen_data_enable = 1'b1;
        gen_frame_start = (l == 0) && (p == 0);
        gen_line_end    = (p == w - 1);
        @(negedge clk);
        if ((l == 0) && (p == 0)) begin
          case (mid_kind)
            1: cfg_dx    = 32'h0000_0022;
            2: cfg_width = 16'd8;
            3: enable    = 1'b0;
            default: ;
          endcase
        end
      end
      if (l < h - 1) begin
        gen_data_enable = 1'b0;
        gen_frame_start = 1'b1;
        gen_line_end    = 1'b1;
        @(negedge clk);
      end
    end
    gen_data_enable = 1'b0;
    gen_frame_start = 1'b0;
    gen_line_end    = 1'b0;
  endtask

  // Counts the falling edges on which gen_resetn is low, up to its rise.
  // The count is bounded; a stuck reset shows up as a wrong count.
  task automatic count_reset_low(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (gen_resetn === 1'b0) begin
        n++;
      end else if (n > 0) begin
        break;
      end
    end
  endtask

  // Monitor. For each frame_done pulse it checks the viewport still held
  // during the pulse, then checks the state that appears one cycle later.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        if (sb.size() == 0) begin
          n_compared++;
          n_mismatched++;
          $display("[TB] FAIL unexpected_frame_done: got pulse, expected none");
        end else begin
          e = sb.pop_front();
          check_output("dx_during_done", dx, e.dx_pre);
          @(negedge clk);
          check_output("frame_count", 32'(frame_count), 32'(e.fc));
          check_output("cr", cr, e.cr);
          check_output("ci", ci, e.ci);
          check_output("anim_dir", 32'(anim_dir), 32'(e.dir));
          check_output("dx_after_done", dx, e.dx_post);
          check_output("width", 32'(width), 32'(e.width));
          check_output("frame_done_pulse", 32'(frame_done), 32'd0);
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  // Main stimulus.
  initial begin
    int n;
    resetn          = 1'b0;
    enable          = 1'b0;
    cfg_width       = 16'd4;
    cfg_height      = 16'd2;
    cfg_cr0         = 32'h0000_0000;
    cfg_ci0         = 32'h1000_0000;
    cfg_cr_step     = 32'h0100_0000;
    cfg_ci_step     = 32'hFFF0_0000;
    cfg_num_frames  = 16'd3;
    cfg_dx          = 32'h0000_0011;
    cfg_dy          = 32'h0000_0033;
    cfg_x0          = 32'h0000_0044;
    cfg_y0          = 32'h0000_0055;
    gen_frame_start = 1'b0;
    gen_line_end    = 1'b0;
    gen_data_enable = 1'b0;

    // Reset values.
    repeat (3) @(negedge clk);
    check_output("rst_gen_resetn", 32'(gen_resetn), 32'd0);
    check_output("rst_width", 32'(width), 32'd0);
    check_output("rst_height", 32'(height), 32'd0);
    check_output("rst_cr", cr, 32'd0);
    check_output("rst_ci", ci, 32'd0);
    check_output("rst_dx", dx, 32'd0);
    check_output("rst_frame_count", 32'(frame_count), 32'd0);
    check_output("rst_frame_done", 32'(frame_done), 32'd0);
    check_output("rst_anim_dir", 32'(anim_dir), 32'd0);

    // Out of reset but not enabled: the block stays idle.
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    check_output("idle_gen_resetn", 32'(gen_resetn), 32'd0);

    // Frames 1-5: 4x2, N=3 ping-pong. Frame 5 changes dx mid-frame.
    expect_frame(16'd1, 32'h0100_0000, 32'h0FF0_0000, 1'b0, 32'h11, 32'h11, 16'd4);
    expect_frame(16'd2, 32'h0200_0000, 32'h0FE0_0000, 1'b1, 32'h11, 32'h11, 16'd4);
    expect_frame(16'd3, 32'h0100_0000, 32'h0FF0_0000, 1'b1, 32'h11, 32'h11, 16'd4);
    expect_frame(16'd4, 32'h0000_0000, 32'h1000_0000, 1'b0, 32'h11, 32'h11, 16'd4);
    expect_frame(16'd5, 32'h0100_0000, 32'h0FF0_0000, 1'b0, 32'h11, 32'h22, 16'd4);

    enable = 1'b1;
    count_reset_low(n);
    check_output("start_reset_cycles", 32'(n), 32'd4);
    check_output("start_gen_resetn", 32'(gen_resetn), 32'd1);
    check_output("start_width", 32'(width), 32'd4);
    check_output("start_height", 32'(height), 32'd2);
    check_output("start_cr", cr, 32'h0000_0000);
    check_output("start_ci", ci, 32'h1000_0000);
    check_output("start_dx", dx, 32'h0000_0011);
    check_output("start_dy", dy, 32'h0000_0033);
    check_output("start_x0", x0, 32'h0000_0044);
    check_output("start_y0", y0, 32'h0000_0055);

    for (int f = 1; f <= 5; f++) begin
      apply_stimulus(4, 2, (f == 5) ? 1 : 0);
      @(negedge clk);
    end

    // Frame 6: width changes mid-frame. The frame still finishes at 4 wide,
    // the generator is reset again, and c is kept.
    expect_frame(16'd6, 32'h0200_0000, 32'h0FE0_0000, 1'b1, 32'h22, 32'h22, 16'd8);
    apply_stimulus(4, 2, 2);
    count_reset_low(n);
    check_output("resize_reset_cycles", 32'(n), 32'd4);
    check_output("resize_cr_kept", cr, 32'h0200_0000);
    check_output("resize_width", 32'(width), 32'd8);

    // Frame 7 at the new size.
    expect_frame(16'd7, 32'h0100_0000, 32'h0FF0_0000, 1'b1, 32'h22, 32'h22, 16'd8);
    apply_stimulus(8, 2, 0);
    @(negedge clk);

    // Frame 8: enable drops mid-frame. The frame completes, then the block goes idle.
    expect_frame(16'd8, 32'h0000_0000, 32'h1000_0000, 1'b0, 32'h22, 32'h22, 16'd8);
    apply_stimulus(8, 2, 3);
    @(negedge clk);
    check_output("stop_gen_resetn", 32'(gen_resetn), 32'd0);
    repeat (3) @(negedge clk);
    check_output("stop_gen_resetn_held", 32'(gen_resetn), 32'd0);
    check_output("stop_frame_count_held", 32'(frame_count), 32'd8);

    // Restart with a new c start value, 1x3 frames and a static c.
    cfg_cr0        = 32'h0300_0000;
    cfg_width      = 16'd1;
    cfg_height     = 16'd3;
    cfg_num_frames = 16'd0;
    enable         = 1'b1;
    count_reset_low(n);
    check_output("restart_reset_cycles", 32'(n), 32'd4);
    check_output("restart_cr_reload", cr, 32'h0300_0000);
    check_output("restart_frame_count_kept", 32'(frame_count), 32'd8);
    check_output("restart_anim_dir", 32'(anim_dir), 32'd0);
    check_output("restart_width", 32'(width), 32'd1);
    check_output("restart_height", 32'(height), 32'd3);

    expect_frame(16'd9, 32'h0300_0000, 32'h1000_0000, 1'b0, 32'h22, 32'h22, 16'd1);
    expect_frame(16'd10, 32'h0300_0000, 32'h1000_0000, 1'b0, 32'h22, 32'h22, 16'd1);
    apply_stimulus(1, 3, 0);
    @(negedge clk);
    apply_stimulus(1, 3, 0);
    @(negedge clk);

    // Reset in the middle of running.
    resetn = 1'b0;
    @(negedge clk);
    check_output("midrst_gen_resetn", 32'(gen_resetn), 32'd0);
    check_output("midrst_frame_count", 32'(frame_count), 32'd0);
    check_output("midrst_cr", cr, 32'd0);
    check_output("midrst_width", 32'(width), 32'd0);
    check_output("midrst_dx", dx, 32'd0);

    repeat (2) @(negedge clk);
    check_output("scoreboard_left", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
